// File: rtl/mhp_pkg.sv
// Shared types and constants for the MHP transmit arbiter.
package mhp_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mhp_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module mhp_rr_pick
    import mhp_pkg::*;
#(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned PW    = idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_SRC-1:0] o_grant,
    output logic [PW-1:0]    o_idx
);

    // Choose the requester with the smallest circular distance from the pointer.
    always_comb begin
        int unsigned w_best;
        int unsigned w_dist;
        int unsigned w_p;
        w_best  = N_SRC;
        w_dist  = 0;
        w_p     = 32'(i_ptr);
        o_idx   = '0;
        o_grant = '0;
        for (int unsigned j = 0; j < N_SRC; j++) begin
            if (i_req[j]) begin
                w_dist = (j >= w_p) ? (j - w_p) : (j + N_SRC - w_p);
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    o_idx  = PW'(j);
                end
            end
        end
        for (int unsigned j = 0; j < N_SRC; j++) begin
            o_grant[j] = (w_best < N_SRC) && (o_idx == PW'(j));
        end
    end

endmodule

// File: rtl/mhp_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one Ethernet byte port between N_SRC sources,
// with inter-frame gap, stall timeout and maximum frame length enforcement.
module mhp_tx_arbiter
    import mhp_pkg::*;
#(
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned IFG_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned MAX_BYTES  = 1500
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_SRC-1:0]        i_req,
    input  logic [BYTE_W*N_SRC-1:0] i_data,
    input  logic [N_SRC-1:0]        i_valid,
    input  logic [N_SRC-1:0]        i_last,
    output logic [N_SRC-1:0]        o_ready,
    output logic [N_SRC-1:0]        o_grant,
    output logic [N_SRC-1:0]        o_done,
    output logic [N_SRC-1:0]        o_abort,
    output logic [BYTE_W-1:0]       o_wdata,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic                    o_busy
);

    localparam int unsigned      PW         = idx_w(N_SRC);
    localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [7:0]       C_IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [PW-1:0]    C_LAST_IDX = PW'(N_SRC - 1);

    arb_state_t       r_state;
    logic [N_SRC-1:0] r_grant;
    logic [N_SRC-1:0] r_done;
    logic [N_SRC-1:0] r_abort;
    logic [PW-1:0]    r_gidx;
    logic [PW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_bytes;
    logic [CNT_W-1:0] r_stall;
    logic [7:0]       r_gap;

    logic [N_SRC-1:0]  w_pick_gnt;
    logic [PW-1:0]     w_pick_idx;
    logic [BYTE_W-1:0] w_wdata;
    logic              w_xfer;
    logic              w_last;
    logic [CNT_W-1:0]  w_bytes_nx;
    logic [CNT_W-1:0]  w_stall_nx;
    logic [PW-1:0]     w_ptr_nx;
    logic              w_end_ok;
    logic              w_end_ab;

    mhp_rr_pick #(
        .N_SRC (N_SRC),
        .PW    (PW)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_gnt),
        .o_idx   (w_pick_idx)
    );

    // r_grant is zero outside SEND, so it alone gates the pass-through path.
    always_comb begin
        w_wdata = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (r_grant[k]) w_wdata = w_wdata | i_data[k*BYTE_W +: BYTE_W];
        end
    end

    assign o_wdata    = w_wdata;
    assign o_wvalid   = |(r_grant & i_valid);
    assign o_ready    = r_grant & {N_SRC{i_wready}};
    assign o_grant    = r_grant;
    assign o_done     = r_done;
    assign o_abort    = r_abort;
    assign o_busy     = (r_state != ARB_IDLE);

    assign w_xfer     = o_wvalid & i_wready;
    assign w_last     = |(r_grant & i_last);
    assign w_bytes_nx = r_bytes + CNT_W'(1);
    assign w_stall_nx = r_stall + CNT_W'(1);
    assign w_ptr_nx   = (r_gidx == C_LAST_IDX) ? '0 : r_gidx + PW'(1);

    // A last byte always wins over the length limit; any transfer defeats the timeout.
    assign w_end_ok = (r_state == ARB_SEND) && w_xfer && w_last;
    assign w_end_ab = (r_state == ARB_SEND) &&
                      ((w_xfer && !w_last && (w_bytes_nx == C_MAX)) ||
                       (!w_xfer && (w_stall_nx == C_TIMEOUT)));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_abort <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_bytes <= '0;
            r_stall <= '0;
            r_gap   <= '0;
        end else begin
            r_done  <= w_end_ok ? r_grant : '0;
            r_abort <= w_end_ab ? r_grant : '0;
            case (r_state)
                ARB_IDLE: begin
                    if (|i_req) begin
                        r_grant <= w_pick_gnt;
                        r_gidx  <= w_pick_idx;
                        r_bytes <= '0;
                        r_stall <= '0;
                        r_state <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (w_xfer) begin
                        r_bytes <= w_bytes_nx;
                        r_stall <= '0;
                    end else begin
                        r_stall <= w_stall_nx;
                    end
                    if (w_end_ok || w_end_ab) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nx;
                        r_gap   <= '0;
                        r_state <= ARB_GAP;
                    end
                end
                ARB_GAP: begin
                    if (r_gap == C_IFG_LAST) r_state <= ARB_IDLE;
                    else                     r_gap   <= r_gap + 8'd1;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mhp_tx_arbiter.sv
// Directed and randomized checks of mhp_tx_arbiter against a frame-level source/arbiter model.
module tb_mhp_tx_arbiter;

    localparam int N    = 2;
    localparam int IFG  = 4;
    localparam int TMO  = 1024;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, valid, last, ready, grant, done, abort;
    logic [15:0] data;
    logic [7:0]  wdata;
    logic        wvalid, wready, busy;

    always #5 clk = ~clk;

    mhp_tx_arbiter #(
        .N_SRC      (N),
        .IFG_CYCLES (IFG),
        .TIMEOUT    (TMO),
        .MAX_BYTES  (MAXB)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_data   (data),
        .i_valid  (valid),
        .i_last   (last),
        .o_ready  (ready),
        .o_grant  (grant),
        .o_done   (done),
        .o_abort  (abort),
        .o_wdata  (wdata),
        .o_wvalid (wvalid),
        .i_wready (wready),
        .o_busy   (busy)
    );

    int nvec = 0;
    int nfail = 0;

    // Arbiter model: current owner, round-robin pointer, per-frame counters and the
    // earliest cycle at which a new grant may be decided (after the gap).
    int cyc_n, own, idle_from, ptr, nbytes, nstall, pulse_kind, pulse_src;

    // Source model: one pending frame per source.
    logic [7:0] fr_data [N][8];
    int fr_len [N], fr_idx [N], fr_stall_at [N], fr_stall_len [N], fr_stalled [N];
    bit fr_pend [N], fr_started [N];
    int auto_len [N];
    int wr_mode;
    bit wr_tog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic load(input int k, input int len, input int sat, input int slen);
        fr_len[k]       = len;
        fr_idx[k]       = 0;
        fr_stall_at[k]  = sat;
        fr_stall_len[k] = slen;
        fr_stalled[k]   = 0;
        fr_pend[k]      = 1'b1;
        fr_started[k]   = 1'b0;
        for (int i = 0; i < 8; i++) fr_data[k][i] = 8'($urandom);
    endtask

    function automatic int pick();
        for (int off = 0; off < N; off++) begin
            if (req[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req[k]   = fr_pend[k] && !fr_started[k];
            valid[k] = fr_pend[k] && !(own == k && fr_idx[k] == fr_stall_at[k] &&
                                       fr_stalled[k] < fr_stall_len[k]);
            last[k]  = fr_pend[k] && (fr_idx[k] == fr_len[k] - 1);
            data[k*8 +: 8] = fr_pend[k] ? fr_data[k][fr_idx[k] % 8] : 8'h00;
        end
        case (wr_mode)
            1:       begin wready = wr_tog; wr_tog = !wr_tog; end
            2:       wready = ($urandom_range(3) != 0);
            default: wready = 1'b1;
        endcase
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        eg = (own >= 0) ? 2'(1 << own) : 2'b00;
        chk("grant",  32'(grant),  32'(eg));
        chk("done",   32'(done),   32'((pulse_kind == 1) ? 2'(1 << pulse_src) : 2'b00));
        chk("abort",  32'(abort),  32'((pulse_kind == 2) ? 2'(1 << pulse_src) : 2'b00));
        chk("busy",   32'(busy),   32'(own >= 0 || cyc_n < idle_from));
        chk("wvalid", 32'(wvalid), 32'((own >= 0) ? valid[own] : 1'b0));
        chk("ready",  32'(ready),  32'(wready ? eg : 2'b00));
        if (own >= 0 && valid[own]) chk("wdata", 32'(wdata), 32'(fr_data[own][fr_idx[own] % 8]));
    endtask

    task automatic end_frame(input int kind);
        int k;
        k          = own;
        pulse_kind = kind;
        pulse_src  = k;
        fr_pend[k] = 1'b0;
        ptr        = (k + 1) % N;
        idle_from  = cyc_n + 1 + IFG;
        own        = -1;
        if (auto_len[k] > 0) load(k, auto_len[k], 99, 0);
        else if (auto_len[k] < 0)
            load(k, int'($urandom_range(1, 6)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    endtask

    task automatic update();
        pulse_kind = 0;
        if (own >= 0) begin
            if (valid[own] && wready) begin
                nbytes++;
                nstall = 0;
                fr_started[own] = 1'b1;
                if (last[own])            end_frame(1);
                else if (nbytes == MAXB)  end_frame(2);
                else                      fr_idx[own]++;
            end else begin
                if (!valid[own]) fr_stalled[own]++;
                nstall++;
                if (nstall == TMO) end_frame(2);
            end
        end else if (cyc_n >= idle_from && req != 2'b00) begin
            own    = pick();
            nbytes = 0;
            nstall = 0;
        end
        cyc_n++;
    endtask

    task automatic cycle();
        drive();
        #1;
        check_outputs();
        update();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},  32'(grant),  32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_abort"},  32'(abort),  32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        chk({tag, "_ready"},  32'(ready),  32'd0);
        chk({tag, "_wdata"},  32'(wdata),  32'd0);
    endtask

    task automatic model_reset();
        cyc_n = 0; idle_from = 0; own = -1; ptr = 0;
        nbytes = 0; nstall = 0; pulse_kind = 0; pulse_src = 0;
    endtask

    task automatic mid_reset();
        drive();
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_async");
        for (int k = 0; k < N; k++) begin
            fr_pend[k]    = 1'b0;
            fr_started[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0;
        req = '0; valid = 2'b11; last = '0; data = 16'hA5A5; wready = 1'b1;
        wr_mode = 0; wr_tog = 1'b1;
        for (int k = 0; k < N; k++) begin
            fr_pend[k] = 1'b0; fr_started[k] = 1'b0; auto_len[k] = 0;
            fr_idx[k] = 0; fr_len[k] = 1; fr_stall_at[k] = 99; fr_stall_len[k] = 0; fr_stalled[k] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        // Test 1: single 3-byte frame AA,BB,CC from src0
        load(0, 3, 99, 0);
        fr_data[0][0] = 8'hAA; fr_data[0][1] = 8'hBB; fr_data[0][2] = 8'hCC;
        run(12);

        // Test 2: both sources request 2-byte frames continuously
        auto_len[0] = 2; auto_len[1] = 2;
        load(0, 2, 99, 0); load(1, 2, 99, 0);
        run(40);
        auto_len[0] = 0; auto_len[1] = 0;
        run(15);

        // Test 3: stall of exactly TIMEOUT cycles aborts, one less completes
        load(1, 3, 1, TMO);
        run(3);
        load(0, 2, 99, 0);
        run(TMO + 20);
        load(1, 3, 1, TMO - 1);
        run(TMO + 20);

        // Test 4: length limit
        load(0, 5, 99, 0);
        run(15);
        load(0, 4, 99, 0);
        run(15);

        // Randomized traffic with stalls and eth back-pressure
        wr_mode = 2;
        auto_len[0] = -1; auto_len[1] = -1;
        load(0, 3, 1, 2); load(1, 5, 2, 1);
        run(600);
        auto_len[0] = 0; auto_len[1] = 0;
        run(80);

        // Test 5: toggling eth ready during src0's frame
        wr_mode = 1; wr_tog = 1'b1;
        load(0, 4, 99, 0);
        run(20);

        // Test 6: reset during byte 2 of src1's frame; pointer must return to 0
        wr_mode = 0;
        load(1, 4, 99, 0);
        for (int i = 0; i < 20 && !(own == 1 && fr_idx[1] == 1); i++) cycle();
        mid_reset();
        load(0, 2, 99, 0); load(1, 2, 99, 0);
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
